gcd_binary_core: RTL and testbench



---
 rtl/gcd_binary_core.sv | 133 +++++++++++++
 tb/tb_gcd_binary_core.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_binary_core.sv
// Binary (Stein) GCD engine: signed operands in, unsigned GCD out, using only
// shifts and subtracts, with a busy/rdy handshake, a zero flag and a LOOP-cycle count.
module gcd_binary_core #(
  parameter int NBits   = 8,
  parameter int CntBits = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NBits-1:0]   xi,
  input  logic [NBits-1:0]   yi,
  output logic [NBits-1:0]   xo,
  output logic               rdy,
  output logic               busy,
  output logic               zero,
  output logic [CntBits-1:0] iters
);

  localparam int KBits = $clog2(NBits + 1);

  typedef enum logic [2:0] {IDLE, LOAD, TWOS, LOOP, DONE} state_t;

  state_t             state, state_nx;
  logic [NBits:0]     xr, yr, xr_nx, yr_nx, xneg, yneg;
  logic [NBits-1:0]   a, b, a_nx, b_nx, xabs, yabs, xo_nx;
  logic [KBits-1:0]   k, k_nx;
  logic [CntBits-1:0] iters_nx;
  logic               zero_nx;

  // Magnitudes of the sign-extended operands; -2^(NBits-1) still fits unsigned.
  always_comb begin
    xneg = '0 - xr;
    yneg = '0 - yr;
    xabs = xr[NBits] ? xneg[NBits-1:0] : xr[NBits-1:0];
    yabs = yr[NBits] ? yneg[NBits-1:0] : yr[NBits-1:0];
  end

  always_comb begin
    state_nx = state;
    xr_nx    = xr;
    yr_nx    = yr;
    a_nx     = a;
    b_nx     = b;
    k_nx     = k;
    xo_nx    = xo;
    zero_nx  = zero;
    iters_nx = iters;
    case (state)
      IDLE: begin
        if (start) begin
          xr_nx    = {xi[NBits-1], xi};
          yr_nx    = {yi[NBits-1], yi};
          state_nx = LOAD;
        end
      end
      LOAD: begin
        a_nx     = xabs;
        b_nx     = yabs;
        k_nx     = '0;
        iters_nx = '0;
        zero_nx  = 1'b0;
        if (xabs == '0 && yabs == '0) begin
          xo_nx    = '0;
          zero_nx  = 1'b1;
          state_nx = DONE;
        end else if (xabs == '0) begin
          xo_nx    = yabs;
          state_nx = DONE;
        end else if (yabs == '0) begin
          xo_nx    = xabs;
          state_nx = DONE;
        end else begin
          state_nx = TWOS;
        end
      end
      TWOS: begin
        if (!a[0] && !b[0]) begin
          a_nx = a >> 1;
          b_nx = b >> 1;
          k_nx = k + 1'b1;
        end else begin
          state_nx = LOOP;
        end
      end
      LOOP: begin
        if (iters != '1) iters_nx = iters + 1'b1;
        // Both odd: the difference is even, so halve it in the same step.
        if (a == b) begin
          xo_nx    = a << k;
          state_nx = DONE;
        end else if (!a[0]) begin
          a_nx = a >> 1;
        end else if (!b[0]) begin
          b_nx = b >> 1;
        end else if (a > b) begin
          a_nx = (a - b) >> 1;
        end else begin
          b_nx = (b - a) >> 1;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      xr    <= '0;
      yr    <= '0;
      a     <= '0;
      b     <= '0;
      k     <= '0;
      xo    <= '0;
      zero  <= 1'b0;
      iters <= '0;
    end else begin
      state <= state_nx;
      xr    <= xr_nx;
      yr    <= yr_nx;
      a     <= a_nx;
      b     <= b_nx;
      k     <= k_nx;
      xo    <= xo_nx;
      zero  <= zero_nx;
      iters <= iters_nx;
    end
  end

  assign busy = (state != IDLE);
  assign rdy  = (state == DONE);

endmodule

// File: tb/tb_gcd_binary_core.sv
// Scoreboarded bench for gcd_binary_core: driver pushes Euclid-derived expectations
// at accept, an independent monitor pops and checks them on every rdy.
module tb_gcd_binary_core;

  localparam int NBits   = 8;
  localparam int CntBits = 6;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [NBits-1:0]   xi = '0, yi = '0;
  logic [NBits-1:0]   xo;
  logic               rdy, busy, zero;
  logic [CntBits-1:0] iters;

  gcd_binary_core #(.NBits(NBits), .CntBits(CntBits)) dut (
    .clk(clk), .rst(rst), .start(start), .xi(xi), .yi(yi),
    .xo(xo), .rdy(rdy), .busy(busy), .zero(zero), .iters(iters)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xo;
    int zero;
    int k;
    int nz;
    int cyc0;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  int   rdy_cnt = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    int ax, ay, n;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    e.xo   = gcd_ref(ax, ay);
    e.zero = (ax == 0 && ay == 0) ? 1 : 0;
    e.nz   = (ax != 0 && ay != 0) ? 1 : 0;
    n = 0;
    if (e.nz != 0)
      while ((((ax | ay) >> n) & 1) == 0) n++;
    e.k    = n;
    e.cyc0 = 0;
    return e;
  endfunction

  // Monitor: pop on rdy, otherwise busy must track outstanding work.
  initial begin
    exp_t e;
    int lat;
    forever begin
      @(negedge clk);
      if (rst && mon_on) begin
        if (rdy) begin
          rdy_cnt++;
          chk("busy_at_rdy", int'(busy), 1);
          if (q.size() == 0) begin
            chk("spurious_rdy", 1, 0);
          end else begin
            e = q.pop_front();
            lat = cyc - e.cyc0 + 1;
            chk("xo", int'(xo), e.xo);
            chk("zero", int'(zero), e.zero);
            chk("k", int'(dut.k), e.k);
            if (e.nz != 0) begin
              chk("iters_nonzero", int'(iters > 0), 1);
              chk("latency", lat, 3 + e.k + 1 + int'(iters));
            end else begin
              chk("iters_zero_op", int'(iters), 0);
              chk("latency", lat, 3);
            end
            chk("latency_bound", int'(lat <= 2*NBits + 4), 1);
          end
        end else begin
          chk("busy", int'(busy), int'(q.size() != 0));
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || q.size() != 0) && n < 100);
    if (n >= 100) chk("idle_timeout", 0, 1);
  endtask

  // Waits for an IDLE cycle, presents operands, and records the expectation at accept.
  task automatic issue(input int x, input int y, input bit hold);
    exp_t e;
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (n >= 100) chk("accept_timeout", 0, 1);
    xi = NBits'(x);
    yi = NBits'(y);
    start = 1'b1;
    e = model(x, y);
    e.cyc0 = cyc;
    @(posedge clk);
    q.push_back(e);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_xo"}, int'(xo), 0);
    chk({tag, "_rdy"}, int'(rdy), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_zero"}, int'(zero), 0);
    chk({tag, "_iters"}, int'(iters), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    mon_on = 1'b1;

    // Directed cases
    issue(48, 18, 0);   wait_idle();
    issue(-12, 8, 0);   wait_idle();
    issue(-128, -128, 0); wait_idle();
    issue(0, 0, 0);     wait_idle();
    issue(0, -7, 0);    wait_idle();
    issue(96, 64, 0);   wait_idle();
    issue(17, 13, 0);   wait_idle();
    issue(-128, 1, 0);  wait_idle();
    issue(127, 0, 0);   wait_idle();

    // Start while busy is dropped
    r0 = rdy_cnt;
    issue(48, 18, 0);
    xi = 8'd5; yi = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("dropped_start_rdy_count", rdy_cnt - r0, 1);

    // Asynchronous reset in LOOP, then accept in the first clock after release
    issue(48, 18, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midreset");
    q.delete();
    @(negedge clk);
    #2;
    r0 = rdy_cnt;
    begin
      exp_t e;
      rst = 1'b1;
      xi = 8'd9; yi = 8'd6; start = 1'b1;
      e = model(9, 6);
      e.cyc0 = cyc;
      @(posedge clk);
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("post_reset_rdy_count", rdy_cnt - r0, 1);

    // Random, one at a time
    for (int i = 0; i < 30; i++) begin
      issue(int'($signed(8'($urandom))), int'($signed(8'($urandom))), 0);
      wait_idle();
    end

    // Random back-to-back with start held high
    for (int i = 0; i < 12; i++)
      issue(int'($signed(8'($urandom_range(0, 255)))), int'($signed(8'($urandom_range(0, 255)))), 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
